// File: rtl/softstart_pkg.sv
// Shared definitions for the soft-start tstate generator: sequencer states and
// parameter defaults.
package softstart_pkg;

  localparam int PRE_CYC_DEF     = 16;
  localparam int STEP_DIV_DEF    = 8;
  localparam int RAMP_W_DEF      = 6;
  localparam int ACK_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_RAMP,
    ST_WAIT,
    ST_DONE,
    ST_FAULT
  } ss_state_e;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/softstart_tstate_gen_sync2.sv
// Two-flop synchronizer for the asynchronous feedback returned from the
// soft-start output path.
module sync2 (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/softstart_tstate_gen.sv
// Soft-start sequencer: precharge hold, reference ramp, tstate launch and
// acknowledge supervision with sticky fault.
module softstart_tstate_gen
  import softstart_pkg::*;
#(
  parameter int PRE_CYC     = PRE_CYC_DEF,
  parameter int STEP_DIV    = STEP_DIV_DEF,
  parameter int RAMP_W      = RAMP_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              en,
  input  logic              o_fb,
  input  logic              CELG,
  input  logic              CELV,
  input  logic              CELSUB,
  output logic              tstate,
  output logic [RAMP_W-1:0] ramp,
  output logic              ss_done,
  output logic              ss_fault
);

  localparam int CNT_MAX = max_of3(PRE_CYC, STEP_DIV, ACK_TIMEOUT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0]  ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [RAMP_W-1:0] RAMP_TOP  = '1;

  ss_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             fb_sync;

  // Supply/ground/substrate pins exist for netlist compatibility only.
  logic unused_supply;
  assign unused_supply = CELG ^ CELV ^ CELSUB;

  sync2 u_fb_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (o_fb),
    .q    (fb_sync)
  );

  // Saturating increment: a counter parked at all-ones never wraps to zero.
  assign cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      tstate    <= 1'b0;
      ramp      <= '0;
      ss_done   <= 1'b0;
      ss_fault  <= 1'b0;
    end else if (!en) begin
      // Dropping the request wins over any acknowledge or timeout this edge.
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      tstate    <= 1'b0;
      ramp      <= '0;
      ss_done   <= 1'b0;
      ss_fault  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_PRE;
          cnt_reg   <= '0;
        end
        ST_PRE: begin
          if (cnt_reg == PRE_LAST) begin
            state_reg <= ST_RAMP;
            cnt_reg   <= '0;
            ramp      <= '0;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        ST_RAMP: begin
          if (ramp == RAMP_TOP) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= '0;
            tstate    <= 1'b1;
          end else if (cnt_reg == STEP_LAST) begin
            cnt_reg <= '0;
            ramp    <= ramp + RAMP_W'(1);
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        ST_WAIT: begin
          if (fb_sync) begin
            state_reg <= ST_DONE;
            ss_done   <= 1'b1;
          end else if (cnt_reg == ACK_LAST) begin
            state_reg <= ST_FAULT;
            tstate    <= 1'b0;
            ramp      <= '0;
            ss_fault  <= 1'b1;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        ST_DONE: begin
          if (!fb_sync) begin
            state_reg <= ST_FAULT;
            tstate    <= 1'b0;
            ramp      <= '0;
            ss_done   <= 1'b0;
            ss_fault  <= 1'b1;
          end
        end
        ST_FAULT: begin
          tstate   <= 1'b0;
          ramp     <= '0;
          ss_done  <= 1'b0;
          ss_fault <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          tstate    <= 1'b0;
          ramp      <= '0;
          ss_done   <= 1'b0;
          ss_fault  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/softstart_tstate_gen.md
SOFTSTART_TSTATE_GEN -- requirements
Module: softstart_tstate_gen

Interface
REQ-001 Parameter PRE_CYC, default 16, sets precharge hold length in clk cycles (range 1..255).
REQ-002 Parameter STEP_DIV, default 8, sets clk cycles per ramp code step (range 1..255).
REQ-003 Parameter RAMP_W, default 6, sets ramp code width in bits.
REQ-004 Parameter ACK_TIMEOUT, default 64, sets the maximum cycles to wait for o_fb after tstate asserts (range 2..1023).
REQ-005 Port clk, input, 1 bit, the single block clock.
REQ-006 Port rstb, input, 1 bit, asynchronous active-low reset.
REQ-007 Port en, input, 1 bit, soft-start request; held high for the whole sequence.
REQ-008 Port o_fb, input, 1 bit, delayed-buffered tstate returned from the soft-start output path; asynchronous to clk.
REQ-009 Port tstate, output, 1 bit, start command driven into the soft-start output path.
REQ-010 Port ramp, output, RAMP_W bits, soft-start reference ramp code.
REQ-011 Port ss_done, output, 1 bit, sequence completed and acknowledged.
REQ-012 Port ss_fault, output, 1 bit, acknowledge timeout or loss.
REQ-013 Ports CELG, CELV and CELSUB, inputs, 1 bit each, supply, ground and substrate; no functional effect.

Function
REQ-014 All outputs SHALL be registered; states SHALL be IDLE, PRE, RAMP, WAIT, DONE and FAULT.
REQ-015 In IDLE, en sampled high SHALL enter PRE on that edge, with the cycle counter cleared.
REQ-016 PRE SHALL last exactly PRE_CYC cycles, then enter RAMP with ramp=0.
REQ-017 In RAMP, ramp SHALL increment by 1 every STEP_DIV cycles and SHALL never wrap.
REQ-018 On the edge after ramp reaches 2^RAMP_W-1, the block SHALL enter WAIT and set tstate=1 on that same edge.
REQ-019 o_fb SHALL pass through a 2-flop synchronizer before use; its value SHALL be ignored outside WAIT and DONE.
REQ-020 In WAIT, synchronized o_fb=1 SHALL enter DONE with ss_done=1, with tstate and ramp held.
REQ-021 In WAIT, ACK_TIMEOUT cycles elapsing without an acknowledge SHALL enter FAULT.
REQ-022 In DONE, synchronized o_fb falling to 0 SHALL enter FAULT.
REQ-023 In FAULT, outputs SHALL be ss_fault=1, tstate=0, ramp=0 and ss_done=0; FAULT is sticky until en is sampled low.
REQ-024 en sampled low in any state SHALL return to IDLE on the next edge and clear tstate, ramp, ss_done and ss_fault.
REQ-025 If en falls on the same edge as an acknowledge or a timeout, en-low SHALL take priority.
REQ-026 Counters SHALL be sized as $clog2 of the largest parameter and SHALL saturate rather than wrap.
REQ-027 ss_done and ss_fault SHALL never be high simultaneously.

Reset
REQ-028 rstb low SHALL asynchronously force IDLE, tstate=0, ramp=0, ss_done=0, ss_fault=0, all counters to 0 and both synchronizer flops to 0.
REQ-029 Reset deassertion SHALL act on the clk edge, and the first en sample SHALL occur on the first edge after release.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence with no residual state.

Structure
REQ-031 A shared package softstart_pkg SHALL hold the state enum and the parameter default constants.
REQ-032 A single sub-module sync2, a 2-flop synchronizer with clk and rstb, SHALL synchronize o_fb.

Verification (defaults; edge 0 = first edge with en sampled high)
REQ-033 en high with o_fb looped back after a 3-cycle delay -> PRE at edge 1; RAMP at edge 17; ramp=63 at edge 521; tstate=1 at edge 522; ss_done=1 by edge 528.
REQ-034 en high with o_fb tied 0 -> tstate=1 at edge 522; ss_fault=1, tstate=0 and ramp=0 at edge 586.
REQ-035 Sequence reaches DONE, then o_fb is forced 0 -> ss_fault=1 within 3 cycles; en low then clears ss_fault the next edge.
REQ-036 en dropped at edge 300 in RAMP -> IDLE at edge 301 with ramp=0; en re-raised -> sequence restarts from PRE.
REQ-037 rstb pulsed low mid-WAIT -> all outputs 0 immediately, with no clk edge required.
REQ-038 en falls on the same edge the synchronized o_fb rises -> IDLE, with ss_done never asserted.
